// File: rtl/mips_wb_pkg.sv
// ============================================================================
// Module      : mips_wb_pkg
// Description : Shared widths, buffered write-back entry type and the
//               byte zero-extension helper for the register write-back unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // One buffered result. 'reg' is a keyword, so the destination is dst_reg.
  typedef struct packed {
    logic [ADDR_W-1:0] dst_reg;
    logic [DATA_W-1:0] data;
    logic              byte_op;
  } wb_entry_t;

  // Byte operations keep only the low byte, zero-extended to full width.
  function automatic logic [DATA_W-1:0] zext_byte(input logic [DATA_W-1:0] d,
                                                  input logic              is_byte);
    return is_byte ? {{(DATA_W-8){1'b0}}, d[7:0]} : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_writeback_unit_if.sv
// ============================================================================
// Module      : reg_writeback_unit_if
// Description : Valid/ready result handshake from the execute/memory stages
//               into the write-back buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_writeback_unit_if;
  import mips_wb_pkg::*;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              wb_byte;

  modport master (output wb_valid, wb_reg, wb_data, wb_byte, input wb_ready);
  modport slave  (input wb_valid, wb_reg, wb_data, wb_byte, output wb_ready);

endinterface

`default_nettype wire

// File: rtl/wb_fifo2.sv
// ============================================================================
// Module      : wb_fifo2
// Description : Two-entry write-back FIFO with flush. Exposes the head (oldest)
//               and the other slot (youngest when full) for bypass compare,
//               plus a registered ready derived from the next occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_fifo2
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  input  wire logic      push,
  input  wire wb_entry_t push_entry,
  input  wire logic      pop,
  input  wire logic      flush,
  output logic [1:0]     count,
  output logic           ready,
  output wb_entry_t      head,
  output wb_entry_t      young
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  wb_entry_t  mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count_nx;
  logic       do_push;
  logic       do_pop;

  // Flush overrides both directions; full/empty guards keep pointers sane.
  assign do_push = push && !flush && (count != FULL);
  assign do_pop  = pop  && !flush && (count != 2'd0);

  // Next occupancy, shared by the count register and the ready register.
  always_comb begin
    count_nx = count;
    if (flush) begin
      count_nx = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_nx = count + 2'd1;
        2'b01:   count_nx = count - 2'd1;
        default: count_nx = count;
      endcase
    end
  end

  // Storage, pointers, occupancy and registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      ready  <= 1'b0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      count <= count_nx;
      ready <= (count_nx < FULL);
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= push_entry;
          wr_ptr      <= ~wr_ptr;
        end
        if (do_pop) rd_ptr <= ~rd_ptr;
      end
    end
  end

  // With two slots the non-head slot always holds the younger entry.
  assign head  = mem[rd_ptr];
  assign young = mem[~rd_ptr];

endmodule

`default_nettype wire

// File: rtl/reg_writeback_unit.sv
// ============================================================================
// Module      : reg_writeback_unit
// Description : Write-back front end for the 32x32 register block. Buffers
//               results, drains one per cycle into the register write port
//               under rf_stall, and forwards buffered values to two readers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_writeback_unit
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  reg_writeback_unit_if.slave    wb,
  input  wire logic              flush,
  input  wire logic              rf_stall,
  output logic                   regWrite,
  output logic [ADDR_W-1:0]      write_reg,
  output logic [DATA_W-1:0]      write_data,
  output logic                   byteOperations,
  input  wire logic [ADDR_W-1:0] read_reg1,
  input  wire logic [ADDR_W-1:0] read_reg2,
  output logic                   byp_hit1,
  output logic                   byp_hit2,
  output logic [DATA_W-1:0]      byp_data1,
  output logic [DATA_W-1:0]      byp_data2
);

  wb_entry_t         in_entry;
  wb_entry_t         head;
  wb_entry_t         young;
  logic [1:0]        count;
  logic              ready;
  logic              push;
  logic              head_valid;
  logic              young_valid;
  logic [ADDR_W-1:0] rd_addr [2];
  logic              hit     [2];
  logic [DATA_W-1:0] hit_data[2];

  // Entry stored at the tail: data is extended before it is buffered.
  always_comb begin
    in_entry.dst_reg = wb.wb_reg;
    in_entry.data    = zext_byte(wb.wb_data, wb.wb_byte);
    in_entry.byte_op = wb.wb_byte;
  end

  // Register 0 results are acknowledged but never buffered.
  assign push        = wb.wb_valid && ready && (wb.wb_reg != '0);
  assign wb.wb_ready = ready;

  assign head_valid  = (count != 2'd0);
  assign young_valid = (count == 2'd2);

  assign regWrite       = head_valid && !rf_stall && !flush;
  assign write_reg      = head_valid ? head.dst_reg : '0;
  assign write_data     = head_valid ? head.data    : '0;
  assign byteOperations = head_valid && head.byte_op;

  wb_fifo2 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (in_entry),
    .pop        (regWrite),
    .flush      (flush),
    .count      (count),
    .ready      (ready),
    .head       (head),
    .young      (young)
  );

  assign rd_addr[0] = read_reg1;
  assign rd_addr[1] = read_reg2;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_byp
      logic              hit_l;
      logic [DATA_W-1:0] data_l;
      // Youngest match wins; the head still forwards while it is being written.
      always_comb begin
        hit_l  = 1'b0;
        data_l = '0;
        if (rd_addr[i] != '0) begin
          if (young_valid && (young.dst_reg == rd_addr[i])) begin
            hit_l  = 1'b1;
            data_l = young.data;
          end else if (head_valid && (head.dst_reg == rd_addr[i])) begin
            hit_l  = 1'b1;
            data_l = head.data;
          end
        end
      end
      assign hit[i]      = hit_l;
      assign hit_data[i] = data_l;
    end
  endgenerate

  assign byp_hit1  = hit[0];
  assign byp_hit2  = hit[1];
  assign byp_data1 = hit_data[0];
  assign byp_data2 = hit_data[1];

endmodule

`default_nettype wire
